// File: rtl/mdu_seq_ctrl.sv
// Iterative multiply/divide sequencer for EX. It stalls the pipeline while the engine runs.
// Defining MDU_FAST_MUL_EN builds a single-cycle multiplier for mult/multu.
module mdu_seq_ctrl #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               op_valid,
  input  logic               op_div,
  input  logic               op_divu,
  input  logic               op_mult,
  input  logic               op_multu,
  input  logic [WIDTH-1:0]   src_a,
  input  logic [WIDTH-1:0]   src_b,
  input  logic               cancel,
  output logic               stallreq,
  output logic               busy,
  output logic               result_valid,
  output logic [2*WIDTH-1:0] result
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_RUN, S_DONE} state_t;
  typedef enum logic [1:0] {OP_DIV, OP_DIVU, OP_MULT, OP_MULTU} op_t;

  state_t             state;
  op_t                op;
  logic [WIDTH-1:0]   op_a, op_b;
  logic [2*WIDTH-1:0] acc;
  logic [CW-1:0]      count;
  logic               neg_lo, neg_hi;

  logic               any_op, is_div, is_signed, sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b, q, r;
  logic [WIDTH:0]     trial, mul_sum;
  logic [2*WIDTH-1:0] iter_next, final_res;

  always_comb begin
    any_op    = op_div | op_divu | op_mult | op_multu;
    is_div    = (op == OP_DIV) || (op == OP_DIVU);
    is_signed = (op == OP_DIV) || (op == OP_MULT);
    sa        = is_signed & op_a[WIDTH-1];
    sb        = is_signed & op_b[WIDTH-1];
    abs_a     = sa ? -op_a : op_a;
    abs_b     = sb ? -op_b : op_b;
    // Divide: acc = {partial remainder, dividend/quotient}; trial is the shifted upper half minus divisor.
    trial     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, op_b};
    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, {WIDTH{acc[0]}} & op_a};
    if (is_div)
      iter_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                               : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      iter_next = {mul_sum, acc[WIDTH-1:1]};
    q = iter_next[WIDTH-1:0];
    r = iter_next[2*WIDTH-1:WIDTH];
    if (is_div)
      final_res = {(neg_hi ? -r : r), (neg_lo ? -q : q)};
    else
      final_res = neg_lo ? -iter_next : iter_next;
  end

`ifdef MDU_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;

  always_comb begin
    if (op == OP_MULT)
      fast_prod = $signed({{WIDTH{op_a[WIDTH-1]}}, op_a}) * $signed({{WIDTH{op_b[WIDTH-1]}}, op_b});
    else
      fast_prod = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
  end
`endif

  assign busy     = (state != S_IDLE);
  assign stallreq = ~rst & ~cancel &
                    (((state == S_IDLE) & op_valid & any_op) | (state == S_CHECK) | (state == S_RUN));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      op           <= OP_DIV;
      op_a         <= '0;
      op_b         <= '0;
      acc          <= '0;
      count        <= '0;
      neg_lo       <= 1'b0;
      neg_hi       <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (op_valid && any_op && !cancel) begin
            op    <= op_div ? OP_DIV : op_divu ? OP_DIVU : op_mult ? OP_MULT : OP_MULTU;
            op_a  <= src_a;
            op_b  <= src_b;
            state <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (cancel) begin
            state <= S_IDLE;
          end else if (is_div && op_b == '0) begin
            result       <= {op_a, {WIDTH{1'b1}}};
            result_valid <= 1'b1;
            state        <= S_DONE;
          end
`ifdef MDU_FAST_MUL_EN
          else if (!is_div) begin
            result       <= fast_prod;
            result_valid <= 1'b1;
            state        <= S_DONE;
          end
`endif
          else begin
            op_a   <= abs_a;
            op_b   <= abs_b;
            acc    <= {{WIDTH{1'b0}}, (is_div ? abs_a : abs_b)};
            neg_lo <= sa ^ sb;
            neg_hi <= sa;
            count  <= '0;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          if (cancel) begin
            state <= S_IDLE;
          end else begin
            acc   <= iter_next;
            count <= count + CW'(1);
            // Last iteration: sign-correct on the fly so the result is registered on entry to DONE.
            if (count == CW'(WIDTH - 1)) begin
              result       <= final_res;
              result_valid <= 1'b1;
              state        <= S_DONE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mdu_seq_ctrl.md
Name: mdu_seq_ctrl

Overview:
- Multi-cycle multiply/divide sequencer sitting in EX.
- Accepts one mult/multu/div/divu operation, holds the pipeline through stallreq while an iterative shift-subtract/shift-add engine runs, then presents a one-cycle {HI,LO} result.
- The result feeds the div_flag/div_result path (ex→mem→wb→ID HI/LO registers and forwarding).

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH. Iteration count = WIDTH.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- op_valid  input  1  EX holds a mult/div instruction; held high while stallreq=1
- op_div  input  1  signed divide
- op_divu  input  1  unsigned divide
- op_mult  input  1  signed multiply
- op_multu  input  1  unsigned multiply
- src_a  input  WIDTH  rs value (dividend / multiplicand)
- src_b  input  WIDTH  rt value (divisor / multiplier)
- cancel  input  1  pipeline flush; aborts any operation in flight
- stallreq  output  1  stall request to the pipeline controller
- busy  output  1  engine occupied (state != IDLE)
- result_valid  output  1  one-cycle pulse; result is valid
- result  output  2*WIDTH  {HI,LO}; div: HI=remainder, LO=quotient; mult: full product

Behaviour:
- Reset (async, rst=1): state=IDLE, count=0, result=0, result_valid=0, internal operand/accumulator registers=0. Outputs go to 0 immediately, without waiting for a clock edge.
- States: IDLE, CHECK, RUN, DONE.
- IDLE:
  - Accept when op_valid and at least one op_* is high.
  - If several op_* are high, priority is div > divu > mult > multu.
  - Latch src_a, src_b and the op type; go to CHECK.
  - Operands are sampled only at acceptance; later changes are ignored.
- CHECK (1 cycle):
  - Signed ops: take absolute values and record quotient sign = a[MSB]^b[MSB] and remainder sign = a[MSB]. For mult, product sign = a^b.
  - Divide by zero (src_b=0, div or divu): skip RUN, go to DONE with LO=all-ones and HI=src_a (raw dividend).
  - Otherwise load count=0 and go to RUN.
- RUN:
  - One iteration per cycle; count increments; leave to DONE when count reaches WIDTH-1.
  - Divide: restoring, 2*WIDTH partial-remainder register. Each cycle shift left 1, trial-subtract divisor from the upper half; if non-negative, keep the difference and set quotient bit=1.
  - Multiply: shift-add, 2*WIDTH accumulator.
- DONE (1 cycle):
  - Apply sign correction to quotient, remainder or product; register the result; result_valid=1; return to IDLE next cycle.
  - Result register holds its value until the next DONE or reset.
- Overflow case: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (natural wrap, no trap).
- stallreq = (state==IDLE & op_valid & any op_*) | state==CHECK | state==RUN. It is low in DONE so the stalled instruction advances in the same cycle result_valid is high.
- In DONE, op_valid is ignored. A new op can be accepted in the IDLE cycle following DONE.
- Latency from acceptance edge: divide/multiply = 1 (CHECK) + WIDTH (RUN) + 1 (DONE); result_valid occurs in cycle WIDTH+2 = 34. Divide-by-zero: result_valid in cycle 2.
- cancel: sampled each edge; in CHECK or RUN it forces IDLE next cycle with result_valid=0.
  - cancel in IDLE blocks acceptance that cycle.
  - cancel in DONE does not suppress the already-asserted result_valid.
  - stallreq is low combinationally while cancel=1.
- Simultaneous rst and cancel: reset wins.

Optional Feature:
- Macro: MDU_FAST_MUL_EN.
- Defined: mult and multu use a single-cycle combinational WIDTH×WIDTH multiplier in CHECK, go straight to DONE, and produce result_valid in cycle 2. Divide is unchanged.
- Not defined: multiply uses the iterative RUN path with latency 34.
- Port list is identical in both builds.

Test Plan:
- divu src_a=100, src_b=7 → stallreq high cycles 0–33; result_valid in cycle 34; result={HI=2, LO=14}; stallreq low in cycle 34.
- div src_a=0xFFFFFFF9 (−7), src_b=2 → LO=0xFFFFFFFD (−3), HI=0xFFFFFFFF (−1); also div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0.
- divu src_a=5, src_b=0 → result_valid in cycle 2; LO=0xFFFFFFFF, HI=5; no RUN cycles.
- mult src_a=0xFFFFFFFE (−2), src_b=3 → result=0xFFFFFFFF_FFFFFFFA in cycle 34 (in cycle 2 with MDU_FAST_MUL_EN); multu of the same operands → 0x00000002_FFFFFFFA.
- Start divu 1000/3, assert cancel in cycle 10 → busy=0 and stallreq=0 from cycle 11; result_valid never pulses. A following divu 9/3 yields HI=0, LO=3.
- Assert rst asynchronously mid-RUN (between edges) → busy, stallreq, result_valid and result go to 0 immediately. After release, op_valid with mult 3×4 yields result=12.
